// File: rtl/operand_stack.sv
// Single-cycle operand stack with PUSH/POP/REPLACE/BINARY/CLEAR and a sticky trap.
// Latency: results visible after the accepting edge; backpressure: ready drops permanently once a trap is raised.
module operand_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         ready,
    output logic [WIDTH-1:0]             top,
    output logic [WIDTH-1:0]             second,
    output logic                         result_empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [2:0]                   trap
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_BINARY  = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;

    localparam logic [2:0] TRAP_NONE  = 3'd0;
    localparam logic [2:0] TRAP_UNDER = 3'd1;
    localparam logic [2:0] TRAP_OVER  = 3'd2;
    localparam logic [2:0] TRAP_ILL   = 3'd3;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q, count_nxt;
    logic [2:0]       trap_q, trap_nxt;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    ptr0, ptr1, ptr2;
    logic             is_empty, is_full, has_two;

    // ptr0 is the next free slot, ptr1 the top, ptr2 the entry below it
    assign ptr0 = AW'(count_q);
    assign ptr1 = AW'(count_q - CW'(1));
    assign ptr2 = AW'(count_q - CW'(2));

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign has_two  = (count_q >= CW'(2));

    assign ready        = (trap_q == TRAP_NONE);
    assign result_empty = is_empty;
    assign full         = is_full;
    assign count        = count_q;
    assign trap         = trap_q;
    assign top          = is_empty ? '0 : mem[ptr1];
    assign second       = has_two  ? mem[ptr2] : '0;

    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = ptr0;
        count_nxt = count_q;
        trap_nxt  = trap_q;
        if (valid && ready) begin
            case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (is_full) begin
                        trap_nxt = TRAP_OVER;
                    end else begin
                        wr_en     = 1'b1;
                        wr_addr   = ptr0;
                        count_nxt = count_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) trap_nxt  = TRAP_UNDER;
                    else          count_nxt = count_q - CW'(1);
                end
                OP_REPLACE: begin
                    if (is_empty) begin
                        trap_nxt = TRAP_UNDER;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = ptr1;
                    end
                end
                OP_BINARY: begin
                    if (!has_two) begin
                        trap_nxt = TRAP_UNDER;
                    end else begin
                        wr_en     = 1'b1;
                        wr_addr   = ptr2;
                        count_nxt = count_q - CW'(1);
                    end
                end
                OP_CLEAR: count_nxt = '0;
                default:  trap_nxt  = TRAP_ILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            count_q <= count_nxt;
            trap_q  <= trap_nxt;
        end
    end

    // Storage is never reset; reads are masked by count so stale slots never leak out
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end
endmodule

// File: tb/tb_operand_stack.sv
// Directed-vector bench for operand_stack at WIDTH=64, DEPTH=4.
module tb_operand_stack;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_BINARY  = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic             result_empty;
    logic             full;
    logic [2:0]       count;
    logic [2:0]       trap;

    int n_tests = 0;
    int n_fail  = 0;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .op           (op),
        .data_in      (data_in),
        .ready        (ready),
        .top          (top),
        .second       (second),
        .result_empty (result_empty),
        .full         (full),
        .count        (count),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic v, input logic [2:0] o, input logic [63:0] d);
        @(negedge clk);
        valid   = v;
        op      = o;
        data_in = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        valid   = 1'b0;
        op      = OP_NOP;
        data_in = '0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_trap",  64'(trap), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_empty", 64'(result_empty), 64'd1);
        check("rst_full",  64'(full), 64'd0);
        check("rst_top",   top, 64'd0);
        check("rst_second", second, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // First push after reset
        do_op(1'b1, OP_PUSH, 64'hc000000000000000);
        check("p1_top",   top, 64'hc000000000000000);
        check("p1_empty", 64'(result_empty), 64'd0);
        check("p1_count", 64'(count), 64'd1);
        check("p1_trap",  64'(trap), 64'd0);

        // PUSH 1, PUSH 2, BINARY 3, REPLACE 7
        apply_reset();
        do_op(1'b1, OP_PUSH, 64'd1);
        do_op(1'b1, OP_PUSH, 64'd2);
        check("p2_top",    top, 64'd2);
        check("p2_second", second, 64'd1);
        do_op(1'b1, OP_BINARY, 64'd3);
        check("bin_top",    top, 64'd3);
        check("bin_second", second, 64'd0);
        check("bin_count",  64'(count), 64'd1);
        do_op(1'b1, OP_REPLACE, 64'd7);
        check("rep_top",   top, 64'd7);
        check("rep_count", 64'(count), 64'd1);
        // valid=0 with PUSH presented must not change anything
        do_op(1'b0, OP_PUSH, 64'd99);
        check("nv_count", 64'(count), 64'd1);
        check("nv_top",   top, 64'd7);
        do_op(1'b1, OP_PUSH, 64'd8);
        do_op(1'b1, OP_POP, 64'd0);
        check("pop_top",   top, 64'd7);
        check("pop_count", 64'(count), 64'd1);

        // Fill to DEPTH, then overflow
        apply_reset();
        for (int i = 1; i <= 4; i++) do_op(1'b1, OP_PUSH, 64'(i));
        check("fill_full",   64'(full), 64'd1);
        check("fill_empty",  64'(result_empty), 64'd0);
        check("fill_top",    top, 64'd4);
        check("fill_second", second, 64'd3);
        do_op(1'b1, OP_PUSH, 64'd5);
        check("ovf_trap",  64'(trap), 64'd2);
        check("ovf_ready", 64'(ready), 64'd0);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_top",   top, 64'd4);
        do_op(1'b1, OP_POP, 64'd0);
        check("ovf_pop_count", 64'(count), 64'd4);
        check("ovf_pop_top",   top, 64'd4);
        check("ovf_pop_trap",  64'(trap), 64'd2);

        // Asynchronous reset mid-cycle while trapped
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_trap",  64'(trap), 64'd0);
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_count", 64'(count), 64'd0);
        check("arst_top",   top, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Underflow cases
        do_op(1'b1, OP_POP, 64'd0);
        check("unf_pop_trap",  64'(trap), 64'd1);
        check("unf_pop_count", 64'(count), 64'd0);
        check("unf_pop_empty", 64'(result_empty), 64'd1);
        apply_reset();
        do_op(1'b1, OP_REPLACE, 64'd3);
        check("unf_rep_trap", 64'(trap), 64'd1);
        apply_reset();
        do_op(1'b1, OP_PUSH, 64'haa);
        do_op(1'b1, OP_BINARY, 64'd5);
        check("unf_bin_trap",  64'(trap), 64'd1);
        check("unf_bin_top",   top, 64'haa);
        check("unf_bin_count", 64'(count), 64'd1);

        // Reserved op
        apply_reset();
        do_op(1'b1, OP_PUSH, 64'h11);
        do_op(1'b0, 3'd6, 64'd0);
        check("ill_nv_trap", 64'(trap), 64'd0);
        check("ill_nv_top",  top, 64'h11);
        do_op(1'b1, 3'd6, 64'd0);
        check("ill_trap",  64'(trap), 64'd3);
        check("ill_ready", 64'(ready), 64'd0);
        check("ill_top",   top, 64'h11);
        apply_reset();
        do_op(1'b1, 3'd7, 64'd0);
        check("ill7_trap", 64'(trap), 64'd3);

        // CLEAR, including on an empty stack
        apply_reset();
        do_op(1'b1, OP_PUSH, 64'd9);
        do_op(1'b1, OP_CLEAR, 64'd0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_top",   top, 64'd0);
        check("clr_trap",  64'(trap), 64'd0);
        check("clr_empty", 64'(result_empty), 64'd1);
        do_op(1'b1, OP_CLEAR, 64'd0);
        check("clr2_trap", 64'(trap), 64'd0);

        // Op presented while reset is held is discarded; next edge accepted
        @(negedge clk);
        reset   = 1'b0;
        valid   = 1'b1;
        op      = OP_PUSH;
        data_in = 64'h55;
        @(posedge clk);
        #1;
        check("rst_op_count", 64'(count), 64'd0);
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        do_op(1'b1, OP_PUSH, 64'h66);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_top",   top, 64'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
